// File: rtl/div_unit_pkg.sv
// Shared widths, FSM state encoding and helpers for the multi-cycle divider.
package div_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(DATA_W) + 1;
    localparam int unsigned RES_W  = 2 * DATA_W;
    localparam int unsigned SHR_W  = 2 * DATA_W + 1;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    // Two's-complement negate when cond is set, pass through otherwise.
    function automatic logic [DATA_W-1:0] neg_if(input logic cond, input logic [DATA_W-1:0] x);
        return cond ? (~x + DATA_W'(1)) : x;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Restoring shift-subtract divider for DIV/DIVU: one quotient bit per cycle, MSB first.
// result_o = {remainder, quotient}; both outputs are plain register outputs.
module div_unit
    import div_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_div_i,
    input  logic [DATA_W-1:0] opdata1_i,
    input  logic [DATA_W-1:0] opdata2_i,
    input  logic              start_i,
    input  logic              annul_i,
    output logic [RES_W-1:0]  result_o,
    output logic              ready_o
);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SHR_W-1:0]  shreg_q, shreg_d;
    logic [DATA_W-1:0] divisor_q, divisor_d;
    logic              sign1_q, sign1_d;
    logic              sign2_q, sign2_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic              ready_q, ready_d;

    // Partial remainder lives in shreg[2W:W]; it can reach 33 bits before the subtract.
    logic [DATA_W:0]   diff;
    logic              rem_ge;

    assign diff   = shreg_q[SHR_W-1:DATA_W] - {1'b0, divisor_q};
    assign rem_ge = shreg_q[SHR_W-1] | ~diff[DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            divisor_q <= '0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            divisor_q <= divisor_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        divisor_d = divisor_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            DIV_FREE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d   = DIV_ON;
                        cnt_d     = '0;
                        sign1_d   = signed_div_i & opdata1_i[DATA_W-1];
                        sign2_d   = signed_div_i & opdata2_i[DATA_W-1];
                        shreg_d   = {DATA_W'(0), neg_if(sign1_d, opdata1_i), 1'b0};
                        divisor_d = neg_if(sign2_d, opdata2_i);
                    end
                end
            end
            DIV_BYZERO: begin
                state_d  = annul_i ? DIV_FREE : DIV_END;
                result_d = '0;
                ready_d  = ~annul_i;
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q != CNT_W'(DATA_W)) begin
                    shreg_d = rem_ge ? {diff[DATA_W-1:0], shreg_q[DATA_W-1:0], 1'b1}
                                     : {shreg_q[SHR_W-2:0], 1'b0};
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    // Quotient sign follows operand signs; remainder takes the dividend's sign.
                    result_d = {neg_if(sign1_q, shreg_q[SHR_W-1:DATA_W+1]),
                                neg_if(sign1_q ^ sign2_q, shreg_q[DATA_W-1:0])};
                    ready_d  = 1'b1;
                    state_d  = DIV_END;
                end
            end
            DIV_END: begin
                if (annul_i || !start_i) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboarded bench for div_unit: directed corners plus randomized DIV/DIVU traffic.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic        prev_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division; signed uses 64-bit truncating arithmetic.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, q, r;
        if (b == 32'd0) return 64'd0;
        if (!sgn) return {a % b, a / b};
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        q = sa / sb_;
        r = sa % sb_;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: pops on each rising ready_o, then checks the result stays put while held.
    always @(negedge clk) begin
        if (rst) begin
            prev_ready <= 1'b0;
        end else begin
            if (ready_o && !prev_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", {63'd0, ready_o}, 64'd0);
                end else begin
                    cur = sb.pop_front();
                    chk("result", result_o, cur.res);
                    chk("latency", 64'(cyc), 64'(cur.cyc));
                end
            end else if (ready_o) begin
                chk("result_hold", result_o, cur.res);
            end
            prev_ready <= ready_o;
        end
    end

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        sb.push_back('{model(sgn, a, b), cyc + ((b == 32'd0) ? 2 : 34)});
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
    endtask

    // Wait for ready while scrambling inputs, which must not affect the result.
    task automatic wait_ready();
        for (int i = 0; i < 60 && !ready_o; i++) begin
            @(negedge clk);
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom_range(0, 1));
        end
        if (!ready_o) begin
            chk("ready_timeout", {63'd0, ready_o}, 64'd1);
            sb.delete();
        end
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
        issue(sgn, a, b);
        wait_ready();
        repeat (hold) @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        chk("release_ready", {63'd0, ready_o}, 64'd0);
        chk("release_result", result_o, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        seen;
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (2) @(negedge clk);
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_result", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_div(1'b0, 32'd100, 32'd7, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 2);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        run_div(1'b1, 32'd5, 32'd0, 1);
        run_div(1'b0, 32'd5, 32'd0, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        run_div(1'b0, 32'd3, 32'd5, 5);
        run_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_div(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);

        // Abort at cnt=10: no result may ever be presented.
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (11) @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        chk("annul_ready", {63'd0, ready_o}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= ready_o;
        end
        chk("annul_never_ready", {63'd0, seen}, 64'd0);
        run_div(1'b0, 32'd9, 32'd3, 0);

        // Async reset mid-ON, between clock edges.
        signed_div_i = 1'b1; opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_on_ready", {63'd0, ready_o}, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Async reset while a result is held in END must clear outputs without an edge.
        issue(1'b1, 32'hFFFF_FF00, 32'd7);
        wait_ready();
        #2 rst = 1'b1;
        #1;
        chk("rst_end_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_end_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) == 0)      rb = 32'd0;
            else if ($urandom_range(0, 1) == 0) rb = 32'($urandom_range(1, 100));
            else                                rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 50));
            run_div(1'($urandom_range(0, 1)), ra, rb, $urandom_range(0, 5));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
